irrigation_scheduler: RTL and testbench

//   Timed sequencer for the irrigation actuators: arbitrates tank water between sprinkler pump (Bs),

---
 rtl/irrigation_scheduler_if.sv | 37 +++
 rtl/irrigation_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_irrigation_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/irrigation_scheduler_if.sv
// -----------------------------------------------------------------------------
// irrigation_scheduler_if
//   Bundle of the raw sensor pins and the actuator/display outputs of the
//   irrigation scheduler.
//   Sensor side   : H, M, L (tank probes), Us (soil dry), Ua (air humid),
//                   T (temperature high)
//   Actuator side : Bs (sprinkler pump), Vs (drip valve), Ve (tank inlet),
//                   Al (alarm), state (FSM code), remaining_sec (ticks left)
//   Modports      : master drives the sensors (board / bench),
//                   slave is the scheduler itself.
// -----------------------------------------------------------------------------
interface irrigation_scheduler_if #(
  parameter int CNT_W = 8
);
  logic             H;
  logic             M;
  logic             L;
  logic             Us;
  logic             Ua;
  logic             T;
  logic             Bs;
  logic             Vs;
  logic             Ve;
  logic             Al;
  logic [2:0]       state;
  logic [CNT_W-1:0] remaining_sec;

  modport master (
    output H, M, L, Us, Ua, T,
    input  Bs, Vs, Ve, Al, state, remaining_sec
  );

  modport slave (
    input  H, M, L, Us, Ua, T,
    output Bs, Vs, Ve, Al, state, remaining_sec
  );
endinterface

// File: rtl/irrigation_scheduler.sv
// -----------------------------------------------------------------------------
// irrigation_scheduler
//   Timed sequencer for the irrigation actuators. Arbitrates tank water
//   between sprinkler pump (Bs), drip valve (Vs) and tank inlet valve (Ve),
//   runs fixed-length watering cycles followed by a rest pause, and raises
//   the alarm (Al).
// Ports
//   clock  : system clock
//   Rst    : synchronous reset, active-high
//   io     : irrigation_scheduler_if.slave (sensors in, actuators out)
// Optional feature
//   REFILL_TIMEOUT_EN : when defined, a refill that keeps Ve open for
//   REFILL_MAX_SEC ticks forces a sticky FAULT that only Rst clears.
// -----------------------------------------------------------------------------
module irrigation_scheduler #(
  parameter int TICK_DIV       = 50_000_000,
  parameter int CNT_W          = 8,
  parameter int SPRINKLE_SEC   = 30,
  parameter int DRIP_SEC       = 60,
  parameter int PAUSE_SEC      = 10,
  parameter int REFILL_MAX_SEC = 120
) (
  input logic                   clock,
  input logic                   Rst,
  irrigation_scheduler_if.slave io
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPRINKLE = 3'd1,
    DRIP     = 3'd2,
    PAUSE    = 3'd3,
    FAULT    = 3'd4
  } state_e;

  typedef struct packed {
    logic h;
    logic m;
    logic l;
    logic us;
    logic ua;
    logic t;
  } sens_t;

  sens_t              sens_q, sens_d;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               ve_q, ve_d;
  logic               al_q, al_d;

  logic [2:0] level;
  logic       tick, err, crit, spr_mode;

`ifdef REFILL_TIMEOUT_EN
  logic [CNT_W-1:0] refill_q, refill_d;
  logic             sticky_q, sticky_d;
`endif

  assign level    = {sens_q.h, sens_q.m, sens_q.l};
  assign tick     = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign crit     = (level == 3'b000);
  assign err      = !(level inside {3'b000, 3'b001, 3'b011, 3'b111});
  assign spr_mode = sens_q.ua & !sens_q.t;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    sens_d  = '{h: io.H, m: io.M, l: io.L, us: io.Us, ua: io.Ua, t: io.T};
    presc_d = tick ? '0 : presc_q + 1'b1;
    state_d = state_q;
    cnt_d   = cnt_q;

    // Priority inside each state: err > water loss > tick expiry.
    unique case (state_q)
      IDLE: begin
        if (err) begin
          state_d = FAULT;
        end else if (sens_q.us && spr_mode && sens_q.m) begin
          state_d = SPRINKLE;
          cnt_d   = CNT_W'(SPRINKLE_SEC);
        end else if (sens_q.us && sens_q.l) begin
          // Sprinkle mode without M falls back to drip here.
          state_d = DRIP;
          cnt_d   = CNT_W'(DRIP_SEC);
        end
      end
      SPRINKLE, DRIP: begin
        if (err) begin
          state_d = FAULT;
          cnt_d   = '0;
        end else if ((state_q == SPRINKLE) ? !sens_q.m : !sens_q.l) begin
          state_d = PAUSE;
          cnt_d   = CNT_W'(PAUSE_SEC);
        end else if (tick) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = PAUSE;
            cnt_d   = CNT_W'(PAUSE_SEC);
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      PAUSE: begin
        if (err) begin
          state_d = FAULT;
          cnt_d   = '0;
        end else if (tick) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      FAULT: begin
        cnt_d = '0;
        if (tick && !err) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

`ifdef REFILL_TIMEOUT_EN
    // Ticks spent with the inlet open; a closed inlet restarts the count.
    refill_d = ve_q ? (tick ? refill_q + 1'b1 : refill_q) : '0;
    sticky_d = sticky_q |
               (ve_q && tick && (refill_q == CNT_W'(REFILL_MAX_SEC - 1)));
    if (sticky_d) begin
      state_d = FAULT;
      cnt_d   = '0;
    end
`endif

    // Inlet valve: set/clear flop, independent of the watering FSM.
    ve_d = ve_q;
    if (err || sens_q.h || (state_d == FAULT)) begin
      ve_d = 1'b0;
    end else if (!sens_q.m) begin
      ve_d = 1'b1;
    end

    // Next state is used so the alarm lines up with the state output.
    al_d = err | crit | (state_d == FAULT);
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Rst) begin
      sens_q  <= '0;
      presc_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      ve_q    <= 1'b0;
      al_q    <= 1'b0;
    end else begin
      sens_q  <= sens_d;
      presc_q <= presc_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ve_q    <= ve_d;
      al_q    <= al_d;
    end
  end

`ifdef REFILL_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (Rst) begin
      refill_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      refill_q <= refill_d;
      sticky_q <= sticky_d;
    end
  end
`endif

  // Pump and drip valve come straight from the state code, so they are exclusive.
  assign io.Bs            = (state_q == SPRINKLE);
  assign io.Vs            = (state_q == DRIP);
  assign io.Ve            = ve_q;
  assign io.Al            = al_q;
  assign io.state         = state_q;
  assign io.remaining_sec = cnt_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// -----------------------------------------------------------------------------
// tb_irrigation_scheduler
//   Directed bench for irrigation_scheduler with TICK_DIV=4, SPRINKLE_SEC=3,
//   DRIP_SEC=5, PAUSE_SEC=2, REFILL_MAX_SEC=6. Inputs change 1 ns after a
//   rising edge and outputs are checked at the same point. After a reset the
//   prescaler is 0, so ticks are consumed on the 4th, 8th, ... edge after
//   release.
// -----------------------------------------------------------------------------
module tb_irrigation_scheduler;

  logic clock = 1'b0;
  logic Rst   = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  irrigation_scheduler_if #(.CNT_W(8)) io ();

  irrigation_scheduler #(
    .TICK_DIV(4), .CNT_W(8), .SPRINKLE_SEC(3), .DRIP_SEC(5),
    .PAUSE_SEC(2), .REFILL_MAX_SEC(6)
  ) dut (
    .clock(clock),
    .Rst  (Rst),
    .io   (io.slave)
  );

  always #5 clock = ~clock;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_in(input logic [2:0] hml, input logic us, input logic ua, input logic t);
    {io.H, io.M, io.L} = hml;
    io.Us = us;
    io.Ua = ua;
    io.T  = t;
  endtask

  // Two reset edges, then release; the next edge is the first functional one.
  task automatic do_reset();
    Rst = 1'b1;
    step(2);
    Rst = 1'b0;
  endtask

  initial begin
    // 1: reset behaviour and sprinkler start
    set_in(3'b111, 1'b1, 1'b1, 1'b0);
    Rst = 1'b1;
    step();
    check("rst_bs",    32'(io.Bs), 0);
    check("rst_vs",    32'(io.Vs), 0);
    check("rst_ve",    32'(io.Ve), 0);
    check("rst_al",    32'(io.Al), 0);
    check("rst_state", 32'(io.state), 0);
    check("rst_rem",   32'(io.remaining_sec), 0);
    step();
    Rst = 1'b0;
    step(2);
    check("spr_state", 32'(io.state), 1);
    check("spr_bs",    32'(io.Bs), 1);
    check("spr_vs",    32'(io.Vs), 0);
    check("spr_rem3",  32'(io.remaining_sec), 3);

    // 2: countdown, pause, re-run
    step(2);
    check("spr_rem2", 32'(io.remaining_sec), 2);
    step(4);
    check("spr_rem1", 32'(io.remaining_sec), 1);
    step(3);
    check("spr_hold_bs", 32'(io.Bs), 1);
    step();
    check("pause_state", 32'(io.state), 3);
    check("pause_bs",    32'(io.Bs), 0);
    check("pause_rem2",  32'(io.remaining_sec), 2);
    step(4);
    check("pause_rem1", 32'(io.remaining_sec), 1);
    step(4);
    check("pause_idle", 32'(io.state), 0);
    step();
    check("rerun_state", 32'(io.state), 1);
    check("rerun_rem",   32'(io.remaining_sec), 3);

    // 3: low level -> drip with refill; refill stops at high level
    set_in(3'b001, 1'b1, 1'b1, 1'b0);
    do_reset();
    step(2);
    check("drip_state", 32'(io.state), 2);
    check("drip_vs",    32'(io.Vs), 1);
    check("drip_bs",    32'(io.Bs), 0);
    check("drip_ve",    32'(io.Ve), 1);
    check("drip_al",    32'(io.Al), 0);
    check("drip_rem",   32'(io.remaining_sec), 5);
    step(3);
    set_in(3'b111, 1'b1, 1'b1, 1'b0);
    step();
    check("refill_hold_ve", 32'(io.Ve), 1);
    step();
    check("refill_done_ve", 32'(io.Ve), 0);
    check("drip_cont",      32'(io.state), 2);
    check("drip_rem4",      32'(io.remaining_sec), 4);

    // 4: water loss in drip -> pause within 2 cycles
    set_in(3'b000, 1'b1, 1'b1, 1'b0);
    step();
    check("loss_still_drip", 32'(io.state), 2);
    step();
    check("loss_state", 32'(io.state), 3);
    check("loss_vs",    32'(io.Vs), 0);
    check("loss_al",    32'(io.Al), 1);
    check("loss_ve",    32'(io.Ve), 1);
    check("loss_rem",   32'(io.remaining_sec), 2);

    // 5: invalid level -> FAULT from PAUSE, exit on tick, then from SPRINKLE
    set_in(3'b101, 1'b1, 1'b1, 1'b0);
    step(2);
    check("flt_state", 32'(io.state), 4);
    check("flt_al",    32'(io.Al), 1);
    check("flt_ve",    32'(io.Ve), 0);
    check("flt_bs_vs", 32'({io.Bs, io.Vs}), 0);
    check("flt_rem",   32'(io.remaining_sec), 0);
    set_in(3'b111, 1'b1, 1'b1, 1'b0);
    step(4);
    check("flt_hold_state", 32'(io.state), 4);
    check("flt_hold_al",    32'(io.Al), 1);
    step();
    check("flt_exit_state", 32'(io.state), 0);
    check("flt_exit_al",    32'(io.Al), 0);
    step();
    check("after_flt_spr", 32'(io.state), 1);
    set_in(3'b101, 1'b1, 1'b1, 1'b0);
    step(2);
    check("spr_flt_state", 32'(io.state), 4);
    check("spr_flt_bs",    32'(io.Bs), 0);
    check("spr_flt_al",    32'(io.Al), 1);

    // Drip mode selected by high temperature, full run to pause
    set_in(3'b111, 1'b1, 1'b1, 1'b1);
    do_reset();
    step(2);
    check("tdrip_state", 32'(io.state), 2);
    check("tdrip_excl",  32'({io.Bs, io.Vs}), 1);
    check("tdrip_ve",    32'(io.Ve), 0);
    check("tdrip_rem",   32'(io.remaining_sec), 5);
    step(17);
    check("tdrip_rem1", 32'(io.remaining_sec), 1);
    step();
    check("tdrip_pause", 32'(io.state), 3);
    check("tdrip_vs",    32'(io.Vs), 0);
    check("tdrip_prem",  32'(io.remaining_sec), 2);

    // 6: long refill with no demand
    set_in(3'b001, 1'b0, 1'b1, 1'b0);
    do_reset();
    step();
    check("rf_ve_on", 32'(io.Ve), 1);
    step(22);
    check("rf_pre_state", 32'(io.state), 0);
    check("rf_pre_ve",    32'(io.Ve), 1);
    step();
`ifdef REFILL_TIMEOUT_EN
    check("rf_to_state", 32'(io.state), 4);
    check("rf_to_al",    32'(io.Al), 1);
    check("rf_to_ve",    32'(io.Ve), 0);
    set_in(3'b111, 1'b0, 1'b1, 1'b0);
    step(8);
    check("rf_sticky_state", 32'(io.state), 4);
    check("rf_sticky_al",    32'(io.Al), 1);
    check("rf_sticky_ve",    32'(io.Ve), 0);
`else
    check("rf_no_to_state", 32'(io.state), 0);
    check("rf_no_to_al",    32'(io.Al), 0);
    check("rf_no_to_ve",    32'(io.Ve), 1);
    step(8);
    check("rf_long_ve", 32'(io.Ve), 1);
    set_in(3'b111, 1'b0, 1'b1, 1'b0);
    step(2);
    check("rf_full_ve", 32'(io.Ve), 0);
`endif
    do_reset();
    check("final_rst_state", 32'(io.state), 0);
    check("final_rst_al",    32'(io.Al), 0);
    check("final_rst_ve",    32'(io.Ve), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
